// File: rtl/dff_bank_rr_arbiter.sv
// dff_bank_rr_arbiter
// Round-robin arbiter that hands exclusive write ownership of one shared
// WIDTH-bit register bank to one of NUM_REQ requesters at a time. Each
// ownership is capped at MAX_HOLD writes; on release the arbiter picks the
// next owner on the same falling edge so back-to-back owners see no idle gap.
// All state changes on the falling edge of clk; reset is asynchronous.

module dff_bank_rr_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*WIDTH-1:0]   wdata,
  output logic [NUM_REQ-1:0]         grant,
  output logic [WIDTH-1:0]           q,
  output logic                       wr_strobe,
  output logic [$clog2(NUM_REQ)-1:0] wr_src,
  output logic                       busy
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_HOLD + 1);

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

  state_t          state;
  logic [IW-1:0]   own;        // index of the current owner (valid in OWN)
  logic [IW-1:0]   ptr;        // round-robin search start
  logic [CW-1:0]   cnt;        // writes performed in the current ownership
  logic [CW-1:0]   cnt_inc;
  logic [IW-1:0]   nxt_ptr;    // owner + 1, wrapped
  logic [IW-1:0]   pick_idle;  // winner searching from ptr
  logic [IW-1:0]   pick_rel;   // winner searching from owner + 1
  logic [WIDTH-1:0] own_wdata;
  logic            own_req;
  logic            hold_done;
  logic            release_now;

  // First requester found searching start, start+1, ... modulo NUM_REQ.
  // The sum is kept one bit wider so non-power-of-two NUM_REQ wraps correctly.
  function automatic logic [IW-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                            input logic [IW-1:0]      start);
    logic [IW:0] s;
    logic        found;
    rr_pick = '0;
    found   = 1'b0;
    for (int unsigned k = 0; k < unsigned'(NUM_REQ); k++) begin
      s = {1'b0, start} + (IW+1)'(k);
      if (s >= (IW+1)'(NUM_REQ)) begin
        s = s - (IW+1)'(NUM_REQ);
      end
      if (!found && r[s[IW-1:0]]) begin
        rr_pick = s[IW-1:0];
        found   = 1'b1;
      end
    end
  endfunction

  // One-hot vector with bit i set.
  function automatic logic [NUM_REQ-1:0] onehot(input logic [IW-1:0] i);
    onehot    = '0;
    onehot[i] = 1'b1;
  endfunction

  // Data lane and request of the current owner.
  always_comb begin
    own_wdata = '0;
    for (int unsigned i = 0; i < unsigned'(NUM_REQ); i++) begin
      if (own == IW'(i)) begin
        own_wdata = wdata[i*WIDTH +: WIDTH];
      end
    end
    own_req = req[own];
  end

  // Hold budget, next search start and both arbitration candidates.
  always_comb begin
    cnt_inc     = cnt + CW'(1);
    hold_done   = (cnt_inc == CW'(MAX_HOLD));
    release_now = !own_req || hold_done;
    nxt_ptr     = (own == IW'(NUM_REQ - 1)) ? '0 : own + IW'(1);
    pick_idle   = rr_pick(req, ptr);
    // Searching from owner+1 puts the departing owner last, so after a
    // forced release it only wins again when nobody else is asking.
    pick_rel    = rr_pick(req, nxt_ptr);
  end

  // Ownership state machine, register bank and write status.
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      grant     <= '0;
      own       <= '0;
      ptr       <= '0;
      cnt       <= '0;
      q         <= '0;
      wr_strobe <= 1'b0;
      wr_src    <= '0;
    end else begin
      case (state)
        IDLE: begin
          wr_strobe <= 1'b0;
          if (|req) begin
            state <= OWN;
            own   <= pick_idle;
            grant <= onehot(pick_idle);
            cnt   <= '0;
          end
        end
        OWN: begin
          if (own_req) begin
            q         <= own_wdata;
            wr_strobe <= 1'b1;
            wr_src    <= own;
            cnt       <= cnt_inc;
          end else begin
            wr_strobe <= 1'b0;
          end
          // Release and re-arbitration share this edge; the later cnt
          // assignment supersedes the increment above.
          if (release_now) begin
            ptr <= nxt_ptr;
            cnt <= '0;
            if (|req) begin
              own   <= pick_rel;
              grant <= onehot(pick_rel);
            end else begin
              state <= IDLE;
              grant <= '0;
            end
          end
        end
        default: begin
          state <= IDLE;
          grant <= '0;
        end
      endcase
    end
  end

  // Status: owned whenever a grant is out.
  always_comb begin
    busy = |grant;
  end

endmodule

// File: tb/tb_dff_bank_rr_arbiter.sv
// tb_dff_bank_rr_arbiter
// Two arbiter instances (MAX_HOLD 4 and 2) share one stimulus stream and are
// compared every falling edge against an integer-level ownership model.

module tb_dff_bank_rr_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int IW = 2;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req;
  logic [N*W-1:0] wdata;

  logic [N-1:0]   grant_a, grant_b;
  logic [W-1:0]   q_a, q_b;
  logic           st_a, st_b;
  logic [IW-1:0]  src_a, src_b;
  logic           busy_a, busy_b;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state per instance (owner -1 means idle).
  int hold  [2] = '{4, 2};
  int m_own [2];
  int m_ptr [2];
  int m_cnt [2];
  int m_q   [2];
  int m_st  [2];
  int m_src [2];

  always #5 clk = ~clk;

  dff_bank_rr_arbiter #(.NUM_REQ(N), .WIDTH(W), .MAX_HOLD(4)) dut_a (
    .clk(clk), .reset(reset), .req(req), .wdata(wdata),
    .grant(grant_a), .q(q_a), .wr_strobe(st_a), .wr_src(src_a), .busy(busy_a)
  );

  dff_bank_rr_arbiter #(.NUM_REQ(N), .WIDTH(W), .MAX_HOLD(2)) dut_b (
    .clk(clk), .reset(reset), .req(req), .wdata(wdata),
    .grant(grant_b), .q(q_b), .wr_strobe(st_b), .wr_src(src_b), .busy(busy_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int arb(input logic [N-1:0] r, input int start);
    for (int k = 0; k < N; k++) begin
      if (r[(start + k) % N]) return (start + k) % N;
    end
    return -1;
  endfunction

  function automatic int wbyte(input logic [N*W-1:0] d, input int o);
    logic [N*W-1:0] t;
    t = d >> (o * W);
    return int'(t[W-1:0]);
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_own[m] = -1; m_ptr[m] = 0; m_cnt[m] = 0;
      m_q[m] = 0; m_st[m] = 0; m_src[m] = 0;
    end
  endtask

  task automatic model_step();
    for (int m = 0; m < 2; m++) begin
      int o;
      bit rel;
      o   = m_own[m];
      rel = 1'b0;
      if (o < 0) begin
        m_st[m] = 0;
        m_own[m] = arb(req, m_ptr[m]);
        m_cnt[m] = 0;
      end else begin
        if (req[o]) begin
          m_q[m] = wbyte(wdata, o);
          m_st[m] = 1;
          m_src[m] = o;
          m_cnt[m]++;
          if (m_cnt[m] == hold[m]) rel = 1'b1;
        end else begin
          m_st[m] = 0;
          rel = 1'b1;
        end
        if (rel) begin
          m_ptr[m] = (o + 1) % N;
          m_own[m] = arb(req, m_ptr[m]);
          m_cnt[m] = 0;
        end
      end
    end
  endtask

  task automatic check_dut(input string id, input int m, input logic [N-1:0] g,
                           input logic [W-1:0] qq, input logic st,
                           input logic [IW-1:0] src, input logic b);
    logic [N-1:0] eg;
    eg = '0;
    if (m_own[m] >= 0) eg[m_own[m]] = 1'b1;
    chk({id, " grant"}, 32'(g), 32'(eg));
    chk({id, " q"}, 32'(qq), m_q[m]);
    chk({id, " wr_strobe"}, 32'(st), m_st[m]);
    chk({id, " wr_src"}, 32'(src), m_src[m]);
    chk({id, " busy"}, 32'(b), (m_own[m] >= 0) ? 1 : 0);
  endtask

  task automatic check_all();
    check_dut("A", 0, grant_a, q_a, st_a, src_a, busy_a);
    check_dut("B", 1, grant_b, q_b, st_b, src_b, busy_b);
  endtask

  task automatic tick();
    @(negedge clk);
    model_step();
    #1;
    check_all();
  endtask

  // Asynchronous pulse between edges; outputs must clear before any edge.
  task automatic do_reset();
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_all();
    #1 reset = 1'b0;
  endtask

  task automatic set_byte(input int i, input logic [W-1:0] v);
    wdata[i*W +: W] = v;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    req   = '0;
    wdata = '0;
    #12;
    model_reset();
    check_all();
    reset = 1'b0;

    // Reset in the middle of an ownership, then search restarts at 0.
    req = 4'b0010; set_byte(1, 8'h5A);
    tick();
    chk("t1 grant1", 32'(grant_a), 32'h2);
    tick();
    chk("t1 q 5A", 32'(q_a), 32'h5A);
    #2 reset = 1'b1;
    #1;
    model_reset();
    chk("t1 rst q", 32'(q_a), 32'h0);
    chk("t1 rst grant", 32'(grant_a), 32'h0);
    chk("t1 rst busy", 32'(busy_a), 32'h0);
    check_all();
    #1 reset = 1'b0;
    req = 4'b1111;
    tick();
    chk("t1 regrant0 A", 32'(grant_a), 32'h1);
    chk("t1 regrant0 B", 32'(grant_b), 32'h1);

    // Single requester.
    do_reset();
    req = 4'b0001; wdata = '0; set_byte(0, 8'hA5);
    tick();
    chk("t2 grant", 32'(grant_a), 32'h1);
    chk("t2 no write", 32'(st_a), 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t2 q", 32'(q_a), 32'hA5);
      chk("t2 strobe", 32'(st_a), 32'h1);
      chk("t2 src", 32'(src_a), 32'h0);
    end
    req = '0;
    tick();

    // Forced rotation between two constant requesters.
    do_reset();
    req = 4'b0011; set_byte(0, 8'h11); set_byte(1, 8'h22);
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 1) chk("t3 first grant", 32'(grant_a), 32'h1);
      if (i == 5) begin
        chk("t3 rotate grant", 32'(grant_a), 32'h2);
        chk("t3 last q0", 32'(q_a), 32'h11);
      end
      if (i == 6) chk("t3 q1 no gap", 32'(q_a), 32'h22);
      if (i == 9) begin
        chk("t3 back grant", 32'(grant_a), 32'h1);
        chk("t3 last q1", 32'(q_a), 32'h22);
      end
    end

    // Each owner drops after one write: order 0,1,2,3,0.
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < 12; i++) begin
      set_byte(i % N, 8'($urandom));
      tick();
      req = 4'b1111;
      if (m_own[0] >= 0 && m_st[0] == 1 && m_src[0] == m_own[0]) req[m_own[0]] = 1'b0;
    end

    // Return to idle, pointer moves past the departed owner.
    do_reset();
    req = 4'b0100; set_byte(2, 8'h3C);
    tick();
    tick();
    req = '0;
    tick();
    chk("t5 idle grant A", 32'(grant_a), 32'h0);
    chk("t5 idle busy A", 32'(busy_a), 32'h0);
    chk("t5 idle grant B", 32'(grant_b), 32'h0);
    req = 4'b1100;
    tick();
    chk("t5 grant3 A", 32'(grant_a), 32'h8);
    chk("t5 grant3 B", 32'(grant_b), 32'h8);

    // Lone requester exhausting its budget is re-granted on the same edge.
    do_reset();
    req = 4'b0100;
    for (int i = 0; i < 8; i++) begin
      set_byte(2, 8'($urandom));
      tick();
      chk("t6 lone grant B", 32'(grant_b), 32'h4);
    end

    // Randomized traffic with occasional asynchronous resets.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      for (int r = 0; r < N; r++) req[r] = ($urandom_range(0, 3) != 0);
      wdata = {$urandom, $urandom};
      if ($urandom_range(0, 49) == 0) do_reset();
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
